// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, length encodings and defaults for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LSB   = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;
  localparam int LEN_UNSIGNED_BIT = 2;

  localparam logic [1:0] IO_BASE_HI_DEFAULT = 2'b11;

endpackage

// File: rtl/mem_arb_line_buf.sv
// rtl/mem_arb_line_buf.sv - icache line assembly buffer, one 32-bit word per fill beat
module mem_arb_line_buf #(
  parameter int LINE_WORDS = 4,
  parameter int CW = $clog2(LINE_WORDS)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [CW-1:0]              cnt,
  input  logic [31:0]                wdata,
  output logic [32*LINE_WORDS-1:0]   line
);

  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      line <= '0;
    end else if (wr_en) begin
      line[32*cnt +: 32] <= wdata;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates icache line fills and LSB accesses onto the memory unit port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         LINE_WORDS = 4,
  parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rob_clear,
  input  logic                      io_buffer_full,
  input  logic                      ic_req,
  input  logic [31:0]               ic_addr,
  output logic                      ic_done,
  output logic [32*LINE_WORDS-1:0]  ic_line,
  input  logic                      lsb_req,
  input  logic                      lsb_wr,
  input  logic [31:0]               lsb_addr,
  input  logic [2:0]                lsb_len,
  input  logic [31:0]               lsb_data,
  output logic                      lsb_done,
  output logic [31:0]               lsb_rdata,
  output logic                      mu_valid,
  output logic                      mu_wr,
  output logic [31:0]               mu_addr,
  output logic [2:0]                mu_len,
  output logic [31:0]               mu_data,
  input  logic                      mu_ready,
  input  logic [31:0]               mu_rdata
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(LINE_WORDS - 1);

  arb_state_t state, state_next;
  arb_state_t last_grant, last_grant_next;
  logic [CW-1:0] cnt, cnt_next;

  logic        mu_valid_next, mu_wr_next;
  logic [31:0] mu_addr_next, mu_data_next;
  logic [2:0]  mu_len_next;
  logic        ic_done_next, lsb_done_next;
  logic [31:0] lsb_rdata_next;
  logic        line_we;

  logic eligible_lsb, eligible_ic;

  // Stores into the IO region are held off while the UART cannot accept them.
  assign eligible_lsb = lsb_req &&
                        !(lsb_wr && (lsb_addr[17:16] == IO_BASE_HI) && io_buffer_full);
  assign eligible_ic  = ic_req;

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    cnt_next        = cnt;
    mu_valid_next   = mu_valid;
    mu_wr_next      = mu_wr;
    mu_addr_next    = mu_addr;
    mu_len_next     = mu_len;
    mu_data_next    = mu_data;
    ic_done_next    = 1'b0;
    lsb_done_next   = 1'b0;
    lsb_rdata_next  = lsb_rdata;
    line_we         = 1'b0;

    case (state)
      IDLE: begin
        if (!ic_done && !lsb_done) begin
          if (eligible_lsb && (!eligible_ic || last_grant == FETCH)) begin
            state_next      = LSB;
            last_grant_next = LSB;
            mu_valid_next   = 1'b1;
            mu_wr_next      = lsb_wr;
            mu_addr_next    = lsb_addr;
            mu_len_next     = lsb_len;
            mu_data_next    = lsb_data;
          end else if (eligible_ic) begin
            state_next      = FETCH;
            last_grant_next = FETCH;
            mu_valid_next   = 1'b1;
            mu_wr_next      = 1'b0;
            mu_addr_next    = ic_addr;
            mu_len_next     = {1'b0, LEN_W};
            mu_data_next    = '0;
            cnt_next        = '0;
          end
        end
      end

      LSB: begin
        if (mu_ready) begin
          lsb_rdata_next = mu_rdata;
          lsb_done_next  = 1'b1;
          mu_valid_next  = 1'b0;
          state_next     = IDLE;
        end
      end

      FETCH: begin
        if (mu_ready) begin
          line_we = 1'b1;
          if (cnt == CNT_LAST) begin
            mu_valid_next = 1'b0;
            ic_done_next  = 1'b1;
            state_next    = IDLE;
          end else begin
            mu_addr_next = mu_addr + 32'd4;
            cnt_next     = cnt + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Flush behaves as reset for everything except the round-robin history.
  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && rob_clear)) begin
      state     <= IDLE;
      cnt       <= '0;
      mu_valid  <= 1'b0;
      mu_wr     <= 1'b0;
      mu_addr   <= '0;
      mu_len    <= '0;
      mu_data   <= '0;
      ic_done   <= 1'b0;
      lsb_done  <= 1'b0;
      lsb_rdata <= '0;
    end else if (rdy_in) begin
      state     <= state_next;
      cnt       <= cnt_next;
      mu_valid  <= mu_valid_next;
      mu_wr     <= mu_wr_next;
      mu_addr   <= mu_addr_next;
      mu_len    <= mu_len_next;
      mu_data   <= mu_data_next;
      ic_done   <= ic_done_next;
      lsb_done  <= lsb_done_next;
      lsb_rdata <= lsb_rdata_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant <= FETCH;
    end else if (rdy_in && !rob_clear) begin
      last_grant <= last_grant_next;
    end
  end

  mem_arb_line_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (rdy_in && rob_clear),
    .wr_en  (rdy_in && !rob_clear && line_we),
    .cnt    (cnt),
    .wdata  (mu_rdata),
    .line   (ic_line)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a byte-serial memory model
module tb_mem_arbiter;

  localparam int LW = 4;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, rob_clear, io_buffer_full;
  logic              ic_req;
  logic [31:0]       ic_addr;
  logic              ic_done;
  logic [32*LW-1:0]  ic_line;
  logic              lsb_req, lsb_wr;
  logic [31:0]       lsb_addr;
  logic [2:0]        lsb_len;
  logic [31:0]       lsb_data;
  logic              lsb_done;
  logic [31:0]       lsb_rdata;
  logic              mu_valid, mu_wr;
  logic [31:0]       mu_addr;
  logic [2:0]        mu_len;
  logic [31:0]       mu_data;
  logic              mu_ready;
  logic [31:0]       mu_rdata;

  mem_arbiter #(.LINE_WORDS(LW), .IO_BASE_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .io_buffer_full(io_buffer_full),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_line(ic_line),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_data(lsb_data), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mu_valid(mu_valid), .mu_wr(mu_wr), .mu_addr(mu_addr), .mu_len(mu_len),
    .mu_data(mu_data), .mu_ready(mu_ready), .mu_rdata(mu_rdata)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Memory unit model: latency 1/2/4 cycles by length, extends loads per the unsigned bit.
  logic [7:0]  mem [0:262143];
  int          lat_cnt = 0;
  logic [17:0] ma;
  logic [31:0] raw;

  function automatic int lat_of(input logic [2:0] len);
    case (len[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 13 + 5);
  endfunction

  assign ma       = mu_addr[17:0];
  assign mu_ready = mu_valid && (lat_cnt == lat_of(mu_len) - 1);

  always_comb begin
    raw = {mem[ma + 18'd3], mem[ma + 18'd2], mem[ma + 18'd1], mem[ma]};
    case (mu_len[1:0])
      2'b00:   mu_rdata = mu_len[2] ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   mu_rdata = mu_len[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: mu_rdata = raw;
    endcase
  end

  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mu_ready) begin
        lat_cnt <= 0;
        if (mu_wr) begin
          mem[ma] <= mu_data[7:0];
          if (mu_len[1:0] != 2'b00) mem[ma + 18'd1] <= mu_data[15:8];
          if (mu_len[1:0] == 2'b10) begin
            mem[ma + 18'd2] <= mu_data[23:16];
            mem[ma + 18'd3] <= mu_data[31:24];
          end
        end
      end else if (mu_valid) begin
        lat_cnt <= lat_cnt + 1;
      end else begin
        lat_cnt <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboards: expectation pushed at issue, popped when the done pulse is consumed.
  typedef struct {
    logic [31:0] rdata;
    logic        chk_rd;
    int          done_cyc;
  } lsb_exp_t;

  typedef struct {
    logic [32*LW-1:0] line;
    int               done_cyc;
  } ic_exp_t;

  lsb_exp_t lsb_q[$];
  ic_exp_t  ic_q[$];

  always @(negedge clk_in) begin : monitor
    lsb_exp_t le;
    ic_exp_t  ie;
    if (lsb_done && rdy_in && !rst_in) begin
      if (lsb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL lsb_unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        le = lsb_q.pop_front();
        chk("lsb_done_cycle", cyc, le.done_cyc);
        if (le.chk_rd) chk("lsb_rdata", lsb_rdata, le.rdata);
      end
    end
    if (ic_done && rdy_in && !rst_in) begin
      if (ic_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ic_unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        ie = ic_q.pop_front();
        chk("ic_done_cycle", cyc, ie.done_cyc);
        chk("ic_line", ic_line, ie.line);
      end
    end
  end

  task automatic lsb_access(input string nm, input logic wr, input logic [31:0] addr,
                            input logic [2:0] len, input logic [31:0] data,
                            input logic [31:0] exp_rd, input logic chk_rd,
                            input int exp_lat, input int exp_valid);
    int c0, vcount;
    logic bus_ok;
    c0 = cyc; vcount = 0; bus_ok = 1'b1;
    lsb_q.push_back('{exp_rd, chk_rd, c0 + exp_lat});
    lsb_req = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_len = len; lsb_data = data;
    forever begin
      @(negedge clk_in);
      if (mu_valid) begin
        vcount++;
        if (mu_addr !== addr || mu_wr !== wr || mu_len !== len || (wr && mu_data !== data))
          bus_ok = 1'b0;
      end
      if (lsb_done && rdy_in) break;
      if (cyc - c0 > 200) begin
        checks++; errors++;
        $display("FAIL %s_timeout: got no lsb_done expected done by cycle %0d", nm, c0 + exp_lat);
        if (lsb_q.size() > 0) lsb_q.delete(lsb_q.size() - 1);
        break;
      end
    end
    if (exp_valid > 0) begin
      chk({nm, "_valid_cycles"}, vcount, exp_valid);
      chk({nm, "_bus_fields"}, bus_ok, 1'b1);
    end
    @(posedge clk_in); #1;
    lsb_req = 1'b0;
  endtask

  task automatic ic_fill(input string nm, input logic [31:0] base, input int exp_lat,
                         input logic chk_addr);
    int c0, k, vcount;
    logic addr_ok;
    logic [32*LW-1:0] exp_line;
    c0 = cyc; vcount = 0; addr_ok = 1'b1;
    for (int i = 0; i < 4 * LW; i++) exp_line[8*i +: 8] = mem[base[17:0] + 18'(i)];
    ic_q.push_back('{exp_line, c0 + exp_lat});
    ic_req = 1'b1; ic_addr = base;
    forever begin
      @(negedge clk_in);
      k = cyc - c0;
      if (mu_valid) vcount++;
      if (k >= 1 && k <= 4 * LW && ((k - 1) % 4) == 0 && mu_addr !== base + 32'(k - 1))
        addr_ok = 1'b0;
      if (ic_done && rdy_in) break;
      if (k > 200) begin
        checks++; errors++;
        $display("FAIL %s_timeout: got no ic_done expected done by cycle %0d", nm, c0 + exp_lat);
        if (ic_q.size() > 0) ic_q.delete(ic_q.size() - 1);
        break;
      end
    end
    if (chk_addr) begin
      chk({nm, "_valid_cycles"}, vcount, 4 * LW);
      chk({nm, "_addr_steps"}, addr_ok, 1'b1);
    end
    @(posedge clk_in); #1;
    ic_req = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] data;
    logic [31:0] exp;
    logic        chk_rd;
    int          lat;
    int          nvalid;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int seen;

    for (int i = 0; i < 262144; i++) mem[i] = pat(i);
    mem[18'h100] = 8'h11; mem[18'h101] = 8'h22; mem[18'h102] = 8'h33; mem[18'h103] = 8'h44;
    mem[18'h200] = 8'h80;
    mem[18'h204] = 8'h34; mem[18'h205] = 8'h92;

    vecs[0]  = '{"lw_100",   1'b0, 32'h100, 3'b010, 32'h0, 32'h44332211, 1'b1, 5, 4};
    vecs[1]  = '{"lb_200",   1'b0, 32'h200, 3'b000, 32'h0, 32'hFFFFFF80, 1'b1, 2, 1};
    vecs[2]  = '{"lbu_200",  1'b0, 32'h200, 3'b100, 32'h0, 32'h00000080, 1'b1, 2, 1};
    vecs[3]  = '{"lh_204",   1'b0, 32'h204, 3'b001, 32'h0, 32'hFFFF9234, 1'b1, 3, 2};
    vecs[4]  = '{"lhu_204",  1'b0, 32'h204, 3'b101, 32'h0, 32'h00009234, 1'b1, 3, 2};
    vecs[5]  = '{"sw_300",   1'b1, 32'h300, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 5, 4};
    vecs[6]  = '{"lw_300",   1'b0, 32'h300, 3'b010, 32'h0, 32'hDEADBEEF, 1'b1, 5, 4};
    vecs[7]  = '{"sb_304",   1'b1, 32'h304, 3'b000, 32'h123456A5, 32'h0, 1'b0, 2, 1};
    vecs[8]  = '{"lw_304",   1'b0, 32'h304, 3'b010, 32'h0,
                 {pat(32'h307), pat(32'h306), pat(32'h305), 8'hA5}, 1'b1, 5, 4};
    vecs[9]  = '{"sh_308",   1'b1, 32'h308, 3'b001, 32'h1234CAFE, 32'h0, 1'b0, 3, 2};
    vecs[10] = '{"lh_308",   1'b0, 32'h308, 3'b001, 32'h0, 32'hFFFFCAFE, 1'b1, 3, 2};
    vecs[11] = '{"lw_308",   1'b0, 32'h308, 3'b010, 32'h0,
                 {pat(32'h30B), pat(32'h30A), 8'hCA, 8'hFE}, 1'b1, 5, 4};

    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_data = '0;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_mu_valid", mu_valid, 1'b0);
    chk("rst_mu_wr", mu_wr, 1'b0);
    chk("rst_mu_addr", mu_addr, 32'h0);
    chk("rst_mu_len", mu_len, 3'h0);
    chk("rst_mu_data", mu_data, 32'h0);
    chk("rst_ic_done", ic_done, 1'b0);
    chk("rst_lsb_done", lsb_done, 1'b0);
    chk("rst_lsb_rdata", lsb_rdata, 32'h0);
    chk("rst_ic_line", ic_line, '0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Tie straight out of reset: LSB first, fill granted the cycle after lsb_done.
    fork
      lsb_access("tie1_lb", 1'b0, 32'h200, 3'b000, 32'h0, 32'hFFFFFF80, 1'b1, 2, 0);
      ic_fill("tie1_fill", 32'h80, 20, 1'b0);
    join

    ic_fill("fill_40", 32'h40, 17, 1'b1);

    for (int i = 0; i < 12; i++)
      lsb_access(vecs[i].nm, vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].data,
                 vecs[i].exp, vecs[i].chk_rd, vecs[i].lat, vecs[i].nvalid);

    // Last grant was LSB, so the fill wins this tie.
    fork
      lsb_access("tie2_lb", 1'b0, 32'h200, 3'b000, 32'h0, 32'hFFFFFF80, 1'b1, 20, 0);
      ic_fill("tie2_fill", 32'h100, 17, 1'b0);
    join

    // rdy_in low across the done pulse stretches it.
    fork
      lsb_access("stretch_lb", 1'b0, 32'h200, 3'b100, 32'h0, 32'h00000080, 1'b1, 4, 0);
      begin
        repeat (2) @(posedge clk_in); #1;
        rdy_in = 1'b0;
        @(negedge clk_in);
        chk("stretch_done_c2", lsb_done, 1'b1);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("stretch_done_c3", lsb_done, 1'b1);
        @(posedge clk_in); #1;
        rdy_in = 1'b1;
      end
    join

    // IO store held off by a full UART while a fill proceeds.
    io_buffer_full = 1'b1;
    fork
      lsb_access("io_sb", 1'b1, 32'h30000, 3'b000, 32'h0000005A, 32'h0, 1'b0, 22, 0);
      ic_fill("io_fill", 32'hC0, 17, 1'b0);
      begin
        repeat (20) @(posedge clk_in); #1;
        io_buffer_full = 1'b0;
      end
    join
    lsb_access("io_lbu", 1'b0, 32'h30000, 3'b100, 32'h0, 32'h0000005A, 1'b1, 2, 1);

    // Flush in the middle of a fill.
    ic_req = 1'b1; ic_addr = 32'h100;
    repeat (7) @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("flush_pre_valid", mu_valid, 1'b1);
    rob_clear = 1'b1; ic_req = 1'b0;
    @(posedge clk_in); #1;
    rob_clear = 1'b0;
    @(negedge clk_in);
    chk("flush_mu_valid", mu_valid, 1'b0);
    chk("flush_mu_addr", mu_addr, 32'h0);
    chk("flush_ic_line", ic_line, '0);
    seen = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (ic_done) seen++;
    end
    chk("flush_no_ic_done", seen, 0);
    @(posedge clk_in); #1;
    ic_fill("refill_100", 32'h100, 17, 1'b1);

    chk("lsb_queue_empty", lsb_q.size(), 0);
    chk("ic_queue_empty", ic_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Sits directly upstream of the byte-serial memory unit and owns its request port.
- Arbitrates between two clients:
  - instruction-cache line fills, delivered as a burst of word reads assembled into one line;
  - load/store-buffer (LSB) single accesses (byte/halfword/word, read or write).
- Also applies UART back-pressure and aborts all in-flight work on pipeline flush.

## Interface

Parameters:
- LINE_WORDS, 4: words per icache line (power of two, ≥2).
- IO_BASE_HI, 2'b11: value of addr[17:16] that marks the IO region.

Ports:
- clk_in  in  1  system clock; the block uses this single clock.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global enable; when low, all state is frozen.
- rob_clear  in  1  flush; aborts all work.
- io_buffer_full  in  1  UART buffer full.
- ic_req  in  1  icache fill request.
- ic_addr  in  32  line base address, line-aligned.
- ic_done  out  1  one-cycle pulse; line valid.
- ic_line  out  32*LINE_WORDS  filled line; word i is at bits [32i+31:32i].
- lsb_req  in  1  LSB access request.
- lsb_wr  in  1  1 = write.
- lsb_addr  in  32  access address.
- lsb_len  in  3  bit 2 = unsigned; bits [1:0]: 00 byte, 01 half, 10 word.
- lsb_data  in  32  store data.
- lsb_done  out  1  one-cycle pulse; access complete.
- lsb_rdata  out  32  load result, extended; valid while lsb_done is high.
- mu_valid, mu_wr  out  1  request to the memory unit.
- mu_addr  out  32  request address.
- mu_len  out  3  request length (same encoding as lsb_len).
- mu_data  out  32  store data.
- mu_ready  in  1  combinational completion flag from the memory unit.
- mu_rdata  in  32  read data; valid in the mu_ready cycle.

## Operation

States:
- IDLE: no access in progress; arbitration happens here.
- LSB: serving one LSB access.
- FETCH: serving an icache line fill; word counter cnt runs 0..LINE_WORDS-1.

Grant rules (IDLE only):
- eligible_lsb = lsb_req && !(lsb_wr && lsb_addr[17:16]==IO_BASE_HI && io_buffer_full).
- eligible_ic = ic_req.
- When both are eligible, round-robin on last_grant. last_grant resets to FETCH, so LSB wins the first tie.
- No grant in a cycle where ic_done or lsb_done is high. Requesters drop or change req at the edge that ends the done cycle.

Actions on grant:
- LSB grant: register wr, addr, len and data into the mu_* outputs; set mu_valid=1; go to LSB.
- FETCH grant: set mu_addr=ic_addr, mu_len=3'b010, mu_wr=0, mu_valid=1, cnt=0; go to FETCH.

LSB state, on mu_ready:
- Latch lsb_rdata=mu_rdata.
- Pulse lsb_done.
- Clear mu_valid.
- Return to IDLE.

FETCH state, on mu_ready:
- Write mu_rdata into word cnt of the line.
- If cnt < LINE_WORDS-1: mu_addr += 4, cnt += 1, mu_valid stays 1.
- If cnt == LINE_WORDS-1: clear mu_valid, pulse ic_done, return to IDLE.

Flush and reset:
- rob_clear has the same effect as reset.
  - All outputs return to 0 and state returns to IDLE; the partial line is discarded.
  - last_grant is kept.
- Clients re-issue any request that had not completed.
- Committed stores must not be in flight at rob_clear; this is an LSB-side guarantee.
- rst_in sets all outputs to 0, state to IDLE and last_grant to FETCH.

## Timing

- All outputs are registered.
- Grant is decided at the edge ending cycle 0; mu_valid is high from cycle 1.
- Memory-unit latency is N cycles, with mu_ready in the Nth cycle of valid: byte 1, half 2, word 4.
- LSB access: lsb_done in cycle N+1, i.e. word 5, half 3, byte 2.
- Fill: words complete in cycles 4, 8, …, 4·LINE_WORDS; ic_done in cycle 4·LINE_WORDS+1 (17 for the default).
- mu_valid stays continuously high across words within a burst; address changes only on the edge after mu_ready.
- mu_* outputs are stable while mu_valid is high, apart from that burst address step.
- Earliest next grant: the cycle after a done pulse.
- rdy_in low holds every register, including done pulses, which stretch.

## Structure

- Package mem_arb_pkg holds:
  - the state enum (IDLE, LSB, FETCH);
  - the len encodings LEN_B, LEN_H, LEN_W and the unsigned bit index;
  - the IO_BASE_HI default.
- One sub-module, mem_arb_line_buf: LINE_WORDS×32 registers with a cnt-indexed write enable and clear.

## Test plan

- LSB lw from 0x100 (memory bytes 11 22 33 44): lsb_done at cycle 5 with lsb_rdata=0x44332211; mu_valid high for cycles 1–4 only.
- LSB lb from an address holding 0x80: lsb_done at cycle 2 with lsb_rdata=0xFFFFFF80. Same access as lbu: lsb_rdata=0x00000080.
- ic_req with addr 0x40, LINE_WORDS=4: mu_addr steps 0x40/0x44/0x48/0x4C at cycles 1/5/9/13; ic_done at 17; ic_line word i equals mem[0x40+4i].
- ic_req and lsb_req both asserted from reset: LSB is served first and the fill starts the cycle after lsb_done. Repeat with both held: grants alternate.
- sb to 0x30000 while io_buffer_full=1: no grant and a pending fill proceeds. Drop full: the store is granted and lsb_done follows at cycle 2 after grant.
- rob_clear at fill cycle 7: mu_valid=0 and state IDLE next cycle; no ic_done. Re-requested fill completes correctly.
